izh_config_sequencer: RTL and testbench

- Sequences configuration and run control of the Izhikevich neuron system.
- On a start request it selects one of four built-in neuron presets (RS, IB, CH, FS) and serializes the 64-bit parameter set onto the loader's serial interface.
- It then waits for the loader's params_ready and gates the neuron core's input enable.
- It counts spikes during the run and exposes a 3-bit state code for the debug pins.

---
 rtl/izh_cfg_pkg.sv | 41 ++++
 rtl/izh_param_serializer.sv | 62 ++++++
 rtl/izh_config_sequencer.sv | 106 ++++++++++
 tb/tb_izh_config_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/izh_cfg_pkg.sv
// Shared types and neuron preset constants for the Izhikevich configuration sequencer.
package izh_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_RUN      = 3'd3,
    ST_ERROR    = 3'd4
  } state_t;

  localparam int FRAME_W = 64;

  // Q8.8 signed parameter words; presets only override the fields that differ from RS.
  localparam logic [15:0] RS_A = 16'h0005;
  localparam logic [15:0] RS_B = 16'h0033;
  localparam logic [15:0] RS_C = 16'hBF00;
  localparam logic [15:0] RS_D = 16'h0800;
  localparam logic [15:0] IB_C = 16'hC900;
  localparam logic [15:0] IB_D = 16'h0400;
  localparam logic [15:0] CH_C = 16'hCE00;
  localparam logic [15:0] CH_D = 16'h0200;
  localparam logic [15:0] FS_A = 16'h001A;
  localparam logic [15:0] FS_D = 16'h0200;

  function automatic logic [FRAME_W-1:0] preset_word(input logic [1:0] sel);
    logic [15:0] a, b, c, d;
    a = RS_A;
    b = RS_B;
    c = RS_C;
    d = RS_D;
    case (sel)
      2'd1: begin c = IB_C; d = IB_D; end
      2'd2: begin c = CH_C; d = CH_D; end
      2'd3: begin a = FS_A; d = FS_D; end
      default: ;
    endcase
    return {a, b, c, d};
  endfunction

endpackage

// File: rtl/izh_param_serializer.sv
// Shifts a 64-bit parameter frame out MSB first, holding each bit for BIT_CYCLES enabled cycles.
module izh_param_serializer
  import izh_cfg_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame,
  output logic               load_mode,
  output logic               serial_data,
  output logic               last_bit_done
);

  localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  logic [FRAME_W-1:0] shift_reg;
  logic [CYC_W-1:0]   cyc_cnt;
  logic [5:0]         bit_cnt;
  logic               bit_done;

  assign bit_done      = (cyc_cnt == CYC_W'(BIT_CYCLES - 1));
  // Decoded from registers so the FSM leaves LOAD on the same edge load_mode drops.
  assign last_bit_done = load_mode && bit_done && (bit_cnt == 6'd63);

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the shift register is reset along with the control state so an aborted frame leaves no stale bits.
      shift_reg   <= '0;
      cyc_cnt     <= '0;
      bit_cnt     <= '0;
      load_mode   <= 1'b0;
      serial_data <= 1'b0;
    end else if (enable) begin
      // NOTE: sequential state uses non-blocking assignments so every branch sees pre-edge values.
      if (load) begin
        shift_reg   <= frame;
        serial_data <= frame[FRAME_W-1];
        load_mode   <= 1'b1;
        cyc_cnt     <= '0;
        bit_cnt     <= '0;
      end else if (load_mode) begin
        if (bit_done) begin
          cyc_cnt <= '0;
          if (bit_cnt == 6'd63) begin
            load_mode   <= 1'b0;
            serial_data <= 1'b0;
          end else begin
            shift_reg   <= {shift_reg[FRAME_W-2:0], 1'b0};
            serial_data <= shift_reg[FRAME_W-2];
            bit_cnt     <= bit_cnt + 6'd1;
          end
        end else begin
          cyc_cnt <= cyc_cnt + CYC_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/izh_config_sequencer.sv
// Run-control FSM: loads a neuron preset through the serializer, waits for the loader, then counts spikes.
module izh_config_sequencer
  import izh_cfg_pkg::*;
#(
  parameter int BIT_CYCLES = 1,
  parameter int TIMEOUT    = 256,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [1:0]       preset_sel,
  input  logic             params_ready,
  input  logic             spike_in,
  output logic             load_mode,
  output logic             serial_data,
  output logic             input_enable,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] spike_count,
  output logic [2:0]       state_code
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic            start_ok;
  logic            last_bit_done;

  // start is only honoured outside an active configuration.
  assign start_ok   = start && (state == ST_IDLE || state == ST_RUN || state == ST_ERROR);
  assign state_code = state;

  izh_param_serializer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_serializer (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .load         (start_ok),
    .frame        (preset_word(preset_sel)),
    .load_mode    (load_mode),
    .serial_data  (serial_data),
    .last_bit_done(last_bit_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      to_cnt       <= '0;
      input_enable <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
      spike_count  <= '0;
    end else if (enable) begin
      case (state)
        ST_IDLE, ST_ERROR: begin
          if (start_ok) begin
            state       <= ST_LOAD;
            busy        <= 1'b1;
            error       <= 1'b0;
            spike_count <= '0;
          end
        end
        ST_LOAD: begin
          if (last_bit_done) begin
            state  <= ST_WAIT_RDY;
            to_cnt <= '0;
          end
        end
        ST_WAIT_RDY: begin
          // params_ready is tested first so it wins over a coincident timeout.
          if (params_ready) begin
            state        <= ST_RUN;
            busy         <= 1'b0;
            input_enable <= 1'b1;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            state <= ST_ERROR;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_RUN: begin
          if (start_ok) begin
            state        <= ST_LOAD;
            busy         <= 1'b1;
            input_enable <= 1'b0;
            spike_count  <= '0;
          end else if (spike_in && (spike_count != '1)) begin
            spike_count <= spike_count + CNT_W'(1);
          end
        end
        default: begin
          state        <= ST_IDLE;
          busy         <= 1'b0;
          input_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_izh_config_sequencer.sv
// Directed bench for izh_config_sequencer: one instance at BIT_CYCLES=1, one at BIT_CYCLES=3.
module tb_izh_config_sequencer;

  localparam logic [63:0] FRAME_RS = 64'h00050033BF000800;
  localparam logic [63:0] FRAME_IB = 64'h00050033C9000400;
  localparam logic [63:0] FRAME_CH = 64'h00050033CE000200;
  localparam logic [63:0] FRAME_FS = 64'h001A0033BF000200;

  logic       clk = 1'b0;
  logic       reset, enable, spike_in;
  logic       start1, start3, params_ready1, params_ready3;
  logic [1:0] preset_sel;

  logic       lm1, sd1, ie1, busy1, err1;
  logic [7:0] sc1;
  logic [2:0] st1;
  logic       lm3, sd3, ie3, busy3, err3;
  logic [7:0] sc3;
  logic [2:0] st3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  izh_config_sequencer #(.BIT_CYCLES(1), .TIMEOUT(256), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .start(start1), .preset_sel(preset_sel),
    .params_ready(params_ready1), .spike_in(spike_in), .load_mode(lm1), .serial_data(sd1),
    .input_enable(ie1), .busy(busy1), .error(err1), .spike_count(sc1), .state_code(st1)
  );

  izh_config_sequencer #(.BIT_CYCLES(3), .TIMEOUT(256), .CNT_W(8)) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .start(start3), .preset_sel(preset_sel),
    .params_ready(params_ready3), .spike_in(spike_in), .load_mode(lm3), .serial_data(sd3),
    .input_enable(ie3), .busy(busy3), .error(err3), .spike_count(sc3), .state_code(st3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic lm_of(input int w);
    return (w == 1) ? lm1 : lm3;
  endfunction

  function automatic logic sd_of(input int w);
    return (w == 1) ? sd1 : sd3;
  endfunction

  // Collects serial_data over every enabled load_mode cycle; optional enable pause and
  // an in-load start pulse (preset 0) at the given bit-sample index.
  task automatic capture(input int w, input int bc, input int pause_at, input int start_at,
                         output logic [63:0] frame, output int hi, output bit stable);
    bit   q[$];
    int   i;
    logic sd0;
    i = 0;
    stable = 1'b1;
    frame = '0;
    while (lm_of(w) && i < 1000) begin
      if (i == pause_at) begin
        sd0 = sd_of(w);
        enable = 1'b0;
        repeat (10) step;
        check("pause_serial_data", {63'd0, sd_of(w)}, {63'd0, sd0});
        check("pause_load_mode", {63'd0, lm_of(w)}, 64'd1);
        enable = 1'b1;
      end
      if (i == start_at) begin
        preset_sel = 2'd0;
        if (w == 1) start1 = 1'b1; else start3 = 1'b1;
      end
      q.push_back(sd_of(w));
      step;
      start1 = 1'b0;
      start3 = 1'b0;
      i++;
    end
    hi = q.size();
    for (int k = 0; k < 64; k++) begin
      for (int j = 0; j < bc; j++) begin
        if (k * bc + j < q.size()) begin
          if (j == 0) frame[63-k] = q[k*bc];
          else if (q[k*bc+j] != q[k*bc]) stable = 1'b0;
        end
      end
    end
  endtask

  logic [63:0] frame;
  int          hi;
  bit          stable;
  int          k;

  initial begin
    reset = 1'b1; enable = 1'b1; spike_in = 1'b0; preset_sel = 2'd0;
    start1 = 1'b0; start3 = 1'b0; params_ready1 = 1'b0; params_ready3 = 1'b0;
    repeat (2) step;
    check("rst_load_mode", {63'd0, lm1}, 64'd0);
    check("rst_serial_data", {63'd0, sd1}, 64'd0);
    check("rst_input_enable", {63'd0, ie1}, 64'd0);
    check("rst_busy", {63'd0, busy1}, 64'd0);
    check("rst_error", {63'd0, err1}, 64'd0);
    check("rst_spike_count", {56'd0, sc1}, 64'd0);
    check("rst_state", {61'd0, st1}, 64'd0);
    check("rst3_flags", {58'd0, lm3, sd3, ie3, busy3, err3, 1'b0}, 64'd0);
    check("rst3_state_count", {53'd0, st3, sc3}, 64'd0);
    reset = 1'b0;
    step;

    // RS preset at BIT_CYCLES=1
    preset_sel = 2'd0; start1 = 1'b1; step; start1 = 1'b0;
    check("rs_state_load", {61'd0, st1}, 64'd1);
    check("rs_busy", {63'd0, busy1}, 64'd1);
    capture(1, 1, -1, -1, frame, hi, stable);
    check("rs_frame", frame, FRAME_RS);
    check("rs_load_cycles", 64'(hi), 64'd64);
    check("rs_state_wait", {61'd0, st1}, 64'd2);
    check("rs_after_sd", {62'd0, lm1, sd1}, 64'd0);

    // params_ready a few cycles after load ends
    repeat (4) step;
    check("wait_hold", {61'd0, st1}, 64'd2);
    params_ready1 = 1'b1; step;
    check("run_state", {61'd0, st1}, 64'd3);
    check("run_input_enable", {63'd0, ie1}, 64'd1);
    check("run_busy", {63'd0, busy1}, 64'd0);
    for (int p = 0; p < 100; p++) begin spike_in = 1'b1; step; spike_in = 1'b0; step; end
    check("spike_100", {56'd0, sc1}, 64'd100);
    for (int p = 0; p < 200; p++) begin spike_in = 1'b1; step; spike_in = 1'b0; step; end
    check("spike_saturate", {56'd0, sc1}, 64'd255);
    params_ready1 = 1'b0; step;
    check("run_pr_fall", {61'd0, st1}, 64'd3);

    // restart from RUN with CH, ignore a start pulse mid-load
    preset_sel = 2'd2; start1 = 1'b1; step; start1 = 1'b0;
    check("restart_ie", {63'd0, ie1}, 64'd0);
    check("restart_lm", {63'd0, lm1}, 64'd1);
    check("restart_count", {56'd0, sc1}, 64'd0);
    check("restart_state", {61'd0, st1}, 64'd1);
    capture(1, 1, -1, 30, frame, hi, stable);
    check("ch_frame", frame, FRAME_CH);
    check("ch_load_cycles", 64'(hi), 64'd64);

    // timeout with params_ready never asserted
    k = 0;
    while (st1 == 3'd2 && k < 400) begin step; k++; end
    check("timeout_cycles", 64'(k), 64'd256);
    check("timeout_state", {61'd0, st1}, 64'd4);
    check("timeout_error", {63'd0, err1}, 64'd1);
    check("timeout_ie", {63'd0, ie1}, 64'd0);
    check("timeout_busy", {63'd0, busy1}, 64'd0);

    // recover with IB, enable paused mid-load, params_ready already high on entry
    params_ready1 = 1'b1;
    preset_sel = 2'd1; start1 = 1'b1; step; start1 = 1'b0;
    check("recover_error", {63'd0, err1}, 64'd0);
    check("recover_state", {61'd0, st1}, 64'd1);
    capture(1, 1, 10, -1, frame, hi, stable);
    check("ib_frame", frame, FRAME_IB);
    check("ib_load_cycles", 64'(hi), 64'd64);
    check("ib_state_wait", {61'd0, st1}, 64'd2);
    step;
    check("early_ready_run", {61'd0, st1}, 64'd3);
    params_ready1 = 1'b0;

    // params_ready on the final timeout cycle wins
    preset_sel = 2'd0; start1 = 1'b1; step; start1 = 1'b0;
    capture(1, 1, -1, -1, frame, hi, stable);
    check("rs2_frame", frame, FRAME_RS);
    repeat (255) step;
    check("edge_wait_state", {61'd0, st1}, 64'd2);
    params_ready1 = 1'b1; step;
    check("edge_ready_wins", {61'd0, st1}, 64'd3);
    check("edge_no_error", {63'd0, err1}, 64'd0);
    params_ready1 = 1'b0;

    // FS at BIT_CYCLES=3 with an enable pause
    preset_sel = 2'd3; start3 = 1'b1; step; start3 = 1'b0;
    check("fs_state_load", {61'd0, st3}, 64'd1);
    capture(3, 3, 20, -1, frame, hi, stable);
    check("fs_frame", frame, FRAME_FS);
    check("fs_load_cycles", 64'(hi), 64'd192);
    check("fs_bit_stable", {63'd0, stable}, 64'd1);
    check("fs_state_wait", {61'd0, st3}, 64'd2);

    // reset around bit 30 of a load
    preset_sel = 2'd0; start1 = 1'b1; step; start1 = 1'b0;
    repeat (30) step;
    check("midreset_pre_lm", {63'd0, lm1}, 64'd1);
    reset = 1'b1; step; reset = 1'b0;
    check("midreset_flags", {59'd0, lm1, sd1, ie1, busy1, err1}, 64'd0);
    check("midreset_state", {61'd0, st1}, 64'd0);
    check("midreset_count", {56'd0, sc1}, 64'd0);

    // start while disabled is dropped
    enable = 1'b0; start1 = 1'b1; step; start1 = 1'b0; enable = 1'b1; step;
    check("disabled_start_state", {61'd0, st1}, 64'd0);
    check("disabled_start_lm", {63'd0, lm1}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
